// File: rtl/u_lsu.sv
// Load/store unit: turns one execute-stage memory op into a req/gnt/rvalid
// transaction and produces a registered register-file write for loads.
module u_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_v,
    output logic        lsu_rdy,
    input  logic        lsu_ld,
    input  logic        lsu_st,
    input  logic [2:0]  lsu_f3,
    input  logic [31:0] lsu_adr,
    input  logic [31:0] lsu_wdat,
    input  logic [4:0]  lsu_rd_a,
    input  logic        flush,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_adr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdat,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdat,
    output logic        wb_e,
    output logic [4:0]  wb_a,
    output logic [31:0] wb_d,
    output logic        lsu_err,
    output logic [31:0] err_adr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;

    logic        w_take;
    logic        w_misal;
    logic        w_err;
    logic        w_go;
    logic [3:0]  w_be;
    logic [31:0] w_wdat;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign lsu_rdy = (r_state == S_IDLE);

    // Request qualification and alignment/legality check at acceptance
    assign w_take  = lsu_v & ~flush & lsu_rdy;
    assign w_misal = (lsu_f3 == 3'b011) | (lsu_f3 == 3'b110) | (lsu_f3 == 3'b111)
                   | ((lsu_f3[1:0] == 2'b01) & lsu_adr[0])
                   | ((lsu_f3 == 3'b010) & (lsu_adr[1:0] != 2'b00));
    assign w_err   = w_take & ((lsu_ld & lsu_st) | ((lsu_ld ^ lsu_st) & w_misal));
    assign w_go    = w_take & (lsu_ld ^ lsu_st) & ~w_misal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go)      w_next = S_REQ;
            S_REQ:   if (dm_gnt)    w_next = S_WAIT;
            S_WAIT:  if (dm_rvalid) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Store lane placement; loads read the whole word
    always_comb begin
        w_be   = 4'b1111;
        w_wdat = lsu_wdat;
        if (lsu_ld) begin
            w_wdat = 32'h0;
        end else begin
            case (lsu_f3[1:0])
                2'b00: begin
                    w_be   = 4'(4'b0001 << lsu_adr[1:0]);
                    w_wdat = {4{lsu_wdat[7:0]}};
                end
                2'b01: begin
                    w_be   = 4'(4'b0011 << lsu_adr[1:0]);
                    w_wdat = {2{lsu_wdat[15:0]}};
                end
                default: begin
                    w_be   = 4'b1111;
                    w_wdat = lsu_wdat;
                end
            endcase
        end
    end

    // Load extraction from the returned word at the latched byte offset
    always_comb begin
        w_byte = dm_rdat[7:0];
        case (r_off)
            2'd0:    w_byte = dm_rdat[7:0];
            2'd1:    w_byte = dm_rdat[15:8];
            2'd2:    w_byte = dm_rdat[23:16];
            default: w_byte = dm_rdat[31:24];
        endcase
        w_half    = r_off[1] ? dm_rdat[31:16] : dm_rdat[15:0];
        w_ld_data = dm_rdat;
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = dm_rdat;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_req  <= 1'b0;
            dm_we   <= 1'b0;
            dm_adr  <= 32'h0;
            dm_be   <= 4'h0;
            dm_wdat <= 32'h0;
            r_f3    <= 3'h0;
            r_off   <= 2'h0;
            r_rd    <= 5'h0;
            wb_e    <= 1'b0;
            wb_a    <= 5'h0;
            wb_d    <= 32'h0;
            lsu_err <= 1'b0;
            err_adr <= 32'h0;
        end else begin
            lsu_err <= w_err;
            if (w_err) begin
                err_adr <= lsu_adr;
            end
            if (w_go) begin
                dm_req  <= 1'b1;
                dm_we   <= lsu_st;
                dm_adr  <= {lsu_adr[31:2], 2'b00};
                dm_be   <= w_be;
                dm_wdat <= w_wdat;
                r_f3    <= lsu_f3;
                r_off   <= lsu_adr[1:0];
                r_rd    <= lsu_rd_a;
            end else if ((r_state == S_REQ) && dm_gnt) begin
                dm_req  <= 1'b0;
            end
            // dm_we doubles as the load/store flag of the outstanding op
            wb_e <= 1'b0;
            if ((r_state == S_WAIT) && dm_rvalid && !dm_we && (r_rd != 5'd0)) begin
                wb_e <= 1'b1;
                wb_a <= r_rd;
                wb_d <= w_ld_data;
            end
        end
    end

endmodule
